retire_trace_buffer: RTL

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

---
 rtl/retire_trace_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: MEM/WB writeback mux plus a first-word-fall-through trace FIFO
// of retired instructions with backpressure, halt draining and sticky overflow.
module retire_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        Halt_Insert,
    input  logic [1:0]  MUX_final,
    input  logic [4:0]  rd,
    input  logic [31:0] Pc_Imm,
    input  logic [31:0] Pc_Four,
    input  logic [31:0] Imm_Out,
    input  logic [31:0] Alu_Result,
    input  logic [31:0] MemReadData,
    input  logic [31:0] Curr_Instr,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic [4:0]  trace_rd,
    output logic        trace_we,
    output logic [31:0] trace_data,
    input  logic        trace_ready,
    output logic        stall_req,
    output logic        halted,
    output logic        overflow,
    output logic [31:0] retire_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // state  | meaning
    // RUN    | normal retirement, records pushed into the trace FIFO
    // DRAIN  | halt retired; pipeline frozen while the FIFO empties
    // HALTED | FIFO drained after halt; terminal until reset
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_next;
    logic           full, push, pop, drop;

    logic [31:0]    mem_pc    [DEPTH];
    logic [31:0]    mem_instr [DEPTH];
    logic [4:0]     mem_rd    [DEPTH];
    logic           mem_we    [DEPTH];
    logic [31:0]    mem_data  [DEPTH];

    always_comb begin
        wb_data = Alu_Result;
        case (MUX_final)
            2'b00:   wb_data = MemtoReg ? MemReadData : Alu_Result;
            2'b01:   wb_data = Pc_Four;
            2'b10:   wb_data = Imm_Out;
            default: wb_data = Pc_Imm;
        endcase
    end

    assign wb_we = wb_valid & RegWrite & (rd != 5'd0) & (state == RUN);
    assign wb_rd = rd;

    assign full        = (count == CW'(DEPTH));
    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push        = wb_valid & (state == RUN) & (~full | pop);
    assign drop        = wb_valid & (state == RUN) & full & ~pop;

    assign trace_pc    = mem_pc[rd_ptr];
    assign trace_instr = mem_instr[rd_ptr];
    assign trace_rd    = mem_rd[rd_ptr];
    assign trace_we    = mem_we[rd_ptr];
    assign trace_data  = mem_data[rd_ptr];

    assign stall_req = (count >= CW'(DEPTH - 1)) | (state != RUN);
    assign halted    = (state == HALTED);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (push && Halt_Insert) state_next = DRAIN;
            DRAIN:   if (count_next == '0)    state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            retire_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_pc[wr_ptr]    <= Pc_Four - 32'd4;
            mem_instr[wr_ptr] <= Curr_Instr;
            mem_rd[wr_ptr]    <= rd;
            mem_we[wr_ptr]    <= wb_we;
            mem_data[wr_ptr]  <= wb_data;
        end
    end

endmodule
